// File: rtl/io_in_port_if.sv
// IO bus bundle shared by the CPU (master) and memory-mapped IO peripherals (slave).
// Loads return data the cycle after ld_re_io; stores are single-cycle with byte enables.
interface io_in_port_if;
   logic        ld_re_io;
   logic [9:0]  ld_adr_io;
   logic [31:0] ld_data_io;
   logic [3:0]  st_we_io;
   logic [9:0]  st_adr_io;
   logic [31:0] st_data_io;

   modport master (
      output ld_re_io, ld_adr_io, st_we_io, st_adr_io, st_data_io,
      input  ld_data_io
   );

   modport slave (
      input  ld_re_io, ld_adr_io, st_we_io, st_adr_io, st_data_io,
      output ld_data_io
   );
endinterface

// File: rtl/io_in_port.sv
// Memory-mapped input port: synchronised, debounced pins with sticky rising-edge flags,
// a per-bit interrupt enable and a registered level interrupt.
module io_in_port #(
   parameter int          N_IN      = 4,
   parameter logic [9:0]  BASE_WADR = 10'h3E0,
   parameter int          DB_DIV    = 50000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_IN-1:0] pin_in,
   io_in_port_if.slave     bus,
   output logic            irq_out
);

   localparam int PW = $clog2(DB_DIV);

   localparam logic [9:0] OFF_LEVEL = 10'd0;
   localparam logic [9:0] OFF_EDGE  = 10'd1;
   localparam logic [9:0] OFF_IRQEN = 10'd2;

   logic [N_IN-1:0]       sync1_q, sync2_q;
   logic [PW-1:0]         presc_q, presc_d;
   logic                  tick;
   logic [N_IN-1:0][1:0]  cnt_q, cnt_d;
   logic [N_IN-1:0]       lvl_q, lvl_d;
   logic [N_IN-1:0]       lvlPrev_q;
   logic [N_IN-1:0]       edg_q, edg_d;
   logic [N_IN-1:0]       irqEn_q, irqEn_d;
   logic [31:0]           ldData_q, ldData_d;
   logic                  irq_q, irq_d;
   logic [N_IN-1:0]       rise;
   logic [N_IN-1:0]       clrMask;
   logic [9:0]            ldOff, stOff;
   logic                  stLow;

   assign tick    = (presc_q == PW'(DB_DIV - 1));
   assign presc_d = tick ? '0 : presc_q + PW'(1);

   // A new level is accepted only after three consecutive ticks that disagree with it.
   always_comb begin
      lvl_d = lvl_q;
      cnt_d = cnt_q;
      if (tick) begin
         for (int i = 0; i < N_IN; i++) begin
            if (sync2_q[i] == lvl_q[i]) begin
               cnt_d[i] = 2'd0;
            end else if (cnt_q[i] == 2'd2) begin
               lvl_d[i] = sync2_q[i];
               cnt_d[i] = 2'd0;
            end else begin
               cnt_d[i] = cnt_q[i] + 2'd1;
            end
         end
      end
   end

   assign ldOff = bus.ld_adr_io - BASE_WADR;
   assign stOff = bus.st_adr_io - BASE_WADR;
   assign stLow = bus.st_we_io[0];
   assign rise  = lvl_q & ~lvlPrev_q;

   // A rise in the same cycle as a write-one-to-clear keeps the flag set.
   always_comb begin
      clrMask = '0;
      irqEn_d = irqEn_q;
      if (stLow && (stOff == OFF_EDGE)) begin
         clrMask = bus.st_data_io[N_IN-1:0];
      end
      if (stLow && (stOff == OFF_IRQEN)) begin
         irqEn_d = bus.st_data_io[N_IN-1:0];
      end
      edg_d = (edg_q & ~clrMask) | rise;
   end

   always_comb begin
      ldData_d = '0;
      if (bus.ld_re_io) begin
         case (ldOff)
            OFF_LEVEL: ldData_d = 32'(lvl_q);
            OFF_EDGE:  ldData_d = 32'(edg_q);
            OFF_IRQEN: ldData_d = 32'(irqEn_q);
            default:   ldData_d = '0;
         endcase
      end
   end

   assign irq_d = |(edg_q & irqEn_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         presc_q   <= '0;
         cnt_q     <= '0;
         lvl_q     <= '0;
         lvlPrev_q <= '0;
         edg_q     <= '0;
         irqEn_q   <= '0;
         ldData_q  <= '0;
         irq_q     <= 1'b0;
      end else begin
         sync1_q   <= pin_in;
         sync2_q   <= sync1_q;
         presc_q   <= presc_d;
         cnt_q     <= cnt_d;
         lvl_q     <= lvl_d;
         lvlPrev_q <= lvl_q;
         edg_q     <= edg_d;
         irqEn_q   <= irqEn_d;
         ldData_q  <= ldData_d;
         irq_q     <= irq_d;
      end
   end

   assign bus.ld_data_io = ldData_q;
   assign irq_out        = irq_q;

endmodule

// File: tb/tb_io_in_port.sv
// Directed bench for io_in_port with a 4-cycle debounce prescaler.
module tb_io_in_port;

   localparam logic [9:0] A_LEVEL = 10'h3E0;
   localparam logic [9:0] A_EDGE  = 10'h3E1;
   localparam logic [9:0] A_IRQEN = 10'h3E2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] pin_in;
   logic       irq_out;
   int         checks = 0;
   int         passed = 0;
   int         edgeCnt;
   logic [31:0] d;

   io_in_port_if bus();

   io_in_port #(.N_IN(4), .BASE_WADR(10'h3E0), .DB_DIV(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .pin_in  (pin_in),
      .bus     (bus),
      .irq_out (irq_out)
   );

   always #5 clk = ~clk;

   // Clock edges since reset release; every 4th edge is a debounce tick.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edgeCnt <= 0;
      else        edgeCnt <= edgeCnt + 1;
   end

   task automatic busIdle();
      bus.ld_re_io   = 1'b0;
      bus.ld_adr_io  = '0;
      bus.st_we_io   = '0;
      bus.st_adr_io  = '0;
      bus.st_data_io = '0;
   endtask

   task automatic doReset(input logic [3:0] pins);
      @(negedge clk);
      rst_n  = 1'b0;
      pin_in = pins;
      busIdle();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic issueLoad(input logic [9:0] adr, output logic [31:0] data);
      bus.ld_re_io  = 1'b1;
      bus.ld_adr_io = adr;
      @(negedge clk);
      bus.ld_re_io  = 1'b0;
      data = bus.ld_data_io;
   endtask

   task automatic doStore(input logic [9:0] adr, input logic [3:0] we, input logic [31:0] data);
      bus.st_we_io   = we;
      bus.st_adr_io  = adr;
      bus.st_data_io = data;
      @(negedge clk);
      bus.st_we_io   = '0;
   endtask

   task automatic test_reset();
      logic [31:0] r;
      doReset(4'hF);
      for (int i = 0; i < 3; i++) begin
         issueLoad(A_LEVEL + 10'(i), r);
         checks++;
         if (r !== 32'h0) $display("[TB] FAIL reset_load%0d actual=%h expected=%h", i, r, 32'h0);
         else passed++;
      end
      checks++;
      if (irq_out !== 1'b0) $display("[TB] FAIL reset_irq actual=%b expected=0", irq_out);
      else passed++;
      repeat (20) @(negedge clk);
      issueLoad(A_LEVEL, r);
      checks++;
      if (r !== 32'hF) $display("[TB] FAIL reset_settled_level actual=%h expected=%h", r, 32'hF);
      else passed++;
      issueLoad(A_EDGE, r);
      checks++;
      if (r !== 32'hF) $display("[TB] FAIL reset_settled_edge actual=%h expected=%h", r, 32'hF);
      else passed++;
      checks++;
      if (irq_out !== 1'b0) $display("[TB] FAIL reset_irq_disabled actual=%b expected=0", irq_out);
      else passed++;
   endtask

   task automatic test_debounce();
      doReset(4'h0);
      pin_in[0] = 1'b1;
      repeat (10) @(negedge clk);
      issueLoad(A_LEVEL, d);
      checks++;
      if (d !== 32'h0) $display("[TB] FAIL debounce_early actual=%h expected=%h", d, 32'h0);
      else passed++;
      repeat (3) @(negedge clk);
      issueLoad(A_LEVEL, d);
      checks++;
      if (d !== 32'h1) $display("[TB] FAIL debounce_level actual=%h expected=%h", d, 32'h1);
      else passed++;
      issueLoad(A_EDGE, d);
      checks++;
      if (d !== 32'h1) $display("[TB] FAIL debounce_edge actual=%h expected=%h", d, 32'h1);
      else passed++;
   endtask

   task automatic test_glitch();
      doStore(A_EDGE, 4'h1, 32'h1);
      issueLoad(A_EDGE, d);
      checks++;
      if (d !== 32'h0) $display("[TB] FAIL glitch_w1c actual=%h expected=%h", d, 32'h0);
      else passed++;
      pin_in[1] = 1'b1;
      repeat (6) @(negedge clk);
      pin_in[1] = 1'b0;
      repeat (30) @(negedge clk);
      issueLoad(A_LEVEL, d);
      checks++;
      if (d !== 32'h1) $display("[TB] FAIL glitch_level actual=%h expected=%h", d, 32'h1);
      else passed++;
      issueLoad(A_EDGE, d);
      checks++;
      if (d !== 32'h0) $display("[TB] FAIL glitch_edge actual=%h expected=%h", d, 32'h0);
      else passed++;
      pin_in[1] = 1'b1;
      repeat (16) @(negedge clk);
      pin_in[1] = 1'b0;
      repeat (30) @(negedge clk);
      issueLoad(A_EDGE, d);
      checks++;
      if (d !== 32'h2) $display("[TB] FAIL long_pulse_edge actual=%h expected=%h", d, 32'h2);
      else passed++;
      issueLoad(A_LEVEL, d);
      checks++;
      if (d !== 32'h1) $display("[TB] FAIL long_pulse_level actual=%h expected=%h", d, 32'h1);
      else passed++;
   endtask

   task automatic test_irq();
      logic [3:0] expIrq [6];
      checks++;
      if (irq_out !== 1'b0) $display("[TB] FAIL irq_idle actual=%b expected=0", irq_out);
      else passed++;
      doStore(A_IRQEN, 4'h1, 32'h2);
      expIrq[0] = {3'b0, irq_out};
      @(negedge clk);
      expIrq[1] = {3'b0, irq_out};
      checks++;
      if (expIrq[0] !== 4'h0 || expIrq[1] !== 4'h1)
         $display("[TB] FAIL irq_enable actual=%b%b expected=01", expIrq[0][0], expIrq[1][0]);
      else passed++;
      issueLoad(A_IRQEN, d);
      checks++;
      if (d !== 32'h2) $display("[TB] FAIL irqen_read actual=%h expected=%h", d, 32'h2);
      else passed++;
      doStore(A_IRQEN, 4'h1, 32'h0);
      expIrq[2] = {3'b0, irq_out};
      @(negedge clk);
      expIrq[3] = {3'b0, irq_out};
      checks++;
      if (expIrq[2] !== 4'h1 || expIrq[3] !== 4'h0)
         $display("[TB] FAIL irq_disable actual=%b%b expected=10", expIrq[2][0], expIrq[3][0]);
      else passed++;
      doStore(A_IRQEN, 4'h1, 32'h2);
      @(negedge clk);
      doStore(A_EDGE, 4'h1, 32'h2);
      expIrq[4] = {3'b0, irq_out};
      @(negedge clk);
      expIrq[5] = {3'b0, irq_out};
      checks++;
      if (expIrq[4] !== 4'h1 || expIrq[5] !== 4'h0)
         $display("[TB] FAIL irq_w1c actual=%b%b expected=10", expIrq[4][0], expIrq[5][0]);
      else passed++;
      issueLoad(A_EDGE, d);
      checks++;
      if (d !== 32'h0) $display("[TB] FAIL irq_edge_cleared actual=%h expected=%h", d, 32'h0);
      else passed++;
   endtask

   task automatic test_collision();
      for (int i = 0; i < 4 && (edgeCnt % 4) != 3; i++) @(negedge clk);
      pin_in[2] = 1'b1;
      repeat (13) @(negedge clk);
      doStore(A_EDGE, 4'h1, 32'h4);
      issueLoad(A_EDGE, d);
      checks++;
      if (d !== 32'h4) $display("[TB] FAIL set_wins actual=%h expected=%h", d, 32'h4);
      else passed++;
      checks++;
      if (irq_out !== 1'b0) $display("[TB] FAIL irq_masked actual=%b expected=0", irq_out);
      else passed++;
      bus.ld_re_io   = 1'b1;
      bus.ld_adr_io  = A_EDGE;
      bus.st_we_io   = 4'h1;
      bus.st_adr_io  = A_EDGE;
      bus.st_data_io = 32'h4;
      @(negedge clk);
      busIdle();
      checks++;
      if (bus.ld_data_io !== 32'h4) $display("[TB] FAIL load_during_w1c actual=%h expected=%h", bus.ld_data_io, 32'h4);
      else passed++;
      issueLoad(A_EDGE, d);
      checks++;
      if (d !== 32'h0) $display("[TB] FAIL after_w1c actual=%h expected=%h", d, 32'h0);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [9:0]  adrs [3];
      logic [31:0] exps [3];
      adrs = '{A_LEVEL, 10'h3E5, A_IRQEN};
      exps = '{32'h5, 32'h0, 32'h2};
      bus.ld_re_io  = 1'b1;
      bus.ld_adr_io = adrs[0];
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i < 2) bus.ld_adr_io = adrs[i+1];
         else       bus.ld_re_io  = 1'b0;
         checks++;
         if (bus.ld_data_io !== exps[i])
            $display("[TB] FAIL b2b_load%0d actual=%h expected=%h", i, bus.ld_data_io, exps[i]);
         else passed++;
      end
      @(negedge clk);
      checks++;
      if (bus.ld_data_io !== 32'h0) $display("[TB] FAIL ld_data_idle actual=%h expected=%h", bus.ld_data_io, 32'h0);
      else passed++;
      doStore(A_IRQEN, 4'h2, 32'hF);
      issueLoad(A_IRQEN, d);
      checks++;
      if (d !== 32'h2) $display("[TB] FAIL upper_byte_enable actual=%h expected=%h", d, 32'h2);
      else passed++;
      doStore(10'h3E3, 4'h1, 32'hFFFF_FFFF);
      issueLoad(10'h3E3, d);
      checks++;
      if (d !== 32'h0) $display("[TB] FAIL offset3 actual=%h expected=%h", d, 32'h0);
      else passed++;
      doStore(A_IRQEN, 4'h1, 32'hFFFF_FFFF);
      issueLoad(A_IRQEN, d);
      checks++;
      if (d !== 32'hF) $display("[TB] FAIL irqen_width actual=%h expected=%h", d, 32'hF);
      else passed++;
   endtask

   task automatic test_reset_mid();
      doReset(4'h5);
      issueLoad(A_IRQEN, d);
      checks++;
      if (d !== 32'h0) $display("[TB] FAIL reset_mid_irqen actual=%h expected=%h", d, 32'h0);
      else passed++;
      issueLoad(A_LEVEL, d);
      checks++;
      if (d !== 32'h0) $display("[TB] FAIL reset_mid_level actual=%h expected=%h", d, 32'h0);
      else passed++;
   endtask

   initial begin
      rst_n  = 1'b0;
      pin_in = '0;
      busIdle();
      test_reset();
      test_debounce();
      test_glitch();
      test_irq();
      test_collision();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/io_in_port.md
Name: io_in_port

Overview:
- Memory-mapped input port on the CPU IO bus.
- It is the read-side counterpart of the LED output port. The LED port only accepts stores; this block returns load data to the CPU.
- It samples external asynchronous inputs (buttons/switches) through a synchronizer and a debouncer, and records rising edges in sticky flags.
- It raises a level interrupt request for enabled edges. Status and control registers are reached through IO loads and stores in the same IO word-address space.

Parameters:
- N_IN, 4, number of input pins (1..8).
- BASE_WADR, 10'h3E0, IO word address (st/ld adr bits [11:2]) of register 0.
- DB_DIV, 50000, prescaler period in clk cycles between debounce samples (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pin_in  in  N_IN  raw asynchronous external inputs.
- ld_re_io  in  1  IO load request, one cycle.
- ld_adr_io  in  10  IO load word address [11:2].
- ld_data_io  out  32  IO load data; valid the cycle after ld_re_io.
- st_we_io  in  4  IO store byte enables.
- st_adr_io  in  10  IO store word address [11:2].
- st_data_io  in  32  IO store data.
- irq_out  out  1  interrupt request, level, registered.

Behaviour:
- Reset (rst_n low, async): the following are all 0:
  - synchronizer flops, prescaler, stable counters, debounced level (lvl), edge flags (edg), irq_en, ld_data_io, irq_out.
  - Reset can occur mid-debounce or mid-load. Nothing survives it. The first load after reset returns 0 for every register.
- Synchronizer: 2 flops per pin, giving pin_s.
- Prescaler:
  - Counts 0..DB_DIV-1 and wraps.
  - tick = 1 for one cycle when the count equals DB_DIV-1.
- Debounce, per bit i, on a tick only:
  - If pin_s[i] == lvl[i]: cnt[i] <= 0.
  - Else if cnt[i] == 2: lvl[i] <= pin_s[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i] + 1.
  - Net effect: a changed level is accepted on the 3rd consecutive differing tick. Any agreeing tick restarts the count.
  - Latency from a pin change to the lvl change is 2 sync cycles + 3 ticks (+ prescaler phase).
- Edge capture:
  - rise[i] = lvl[i] goes 0->1 (compare against the previous-cycle lvl). A rise sets edg[i].
  - Falling transitions are not captured.
- Register map (word offset from BASE_WADR):
  - 0 LEVEL: RO, bits [N_IN-1:0] = lvl.
  - 1 EDGE: bits = edg. A store with st_we_io[0]=1 clears every bit whose st_data_io bit is 1 (W1C).
  - 2 IRQEN: RW, bits = irq_en. Stored from st_data_io[N_IN-1:0] when st_we_io[0]=1.
  - Offset 3 and other addresses: loads return 0, stores ignored.
  - Bits above N_IN read as 0.
  - Byte enables 1..3 have no effect.
- Load timing:
  - ld_re_io with a matching address in cycle t gives ld_data_io = register value sampled at t, in cycle t+1.
  - ld_data_io returns to 0 in any cycle following no load or a non-matching load.
  - Back-to-back loads are supported every cycle.
- Simultaneous events:
  - W1C on EDGE in the same cycle as a new rise on the same bit: the set wins and the bit stays 1.
  - A load of EDGE in the same cycle as a W1C store returns the pre-clear value.
  - A store to IRQEN takes effect on the next irq_out evaluation (the cycle after the store).
- irq_out: registered each cycle as |(edg & irq_en). This is one cycle after edg/irq_en change. It drops one cycle after the W1C clear.

Test Plan:
- Reset: hold rst_n=0 with pin_in=4'hF → release → load offsets 0/1/2 (10'h3E0/3E1/3E2) all return 0 and irq_out=0 until debounce completes.
- Debounce, DB_DIV=4:
  - Drive pin_in[0] 0→1. lvl[0] stays 0 after 2 ticks and becomes 1 after the 3rd tick.
  - Load LEVEL → 32'h1. Load EDGE → 32'h1.
- Glitch rejection:
  - Pulse pin_in[1] high for 1.5 ticks (DB_DIV=4) → LEVEL and EDGE stay 0.
  - A pulse lasting ≥3 ticks + 2 cycles → EDGE = 32'h2.
- Interrupt:
  - Store IRQEN=32'h2 (st_we_io=4'h1) with EDGE[1]=1 → irq_out=1 one cycle later.
  - Store EDGE ← 32'h2 → irq_out=0 one cycle after.
  - Store IRQEN=0 instead → irq_out=0.
- Set-wins collision: force a rise on bit 2 in the same cycle as a W1C store of 32'h4 → EDGE reads 32'h4 afterwards.
- Load pipeline:
  - Back-to-back loads of 3E0, 3E5, 3E2 → ld_data_io over the next three cycles = LEVEL, 0, IRQEN.
  - A store with st_we_io=4'h2 to IRQEN → no change.
